// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with pin synchronisers, glitch filters, frame checking,
// timeout and a first-word-fall-through scan-code FIFO. Optional prefix folding: PS2_PREFIX_DECODE_EN.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            rd_en,
  output logic                            key_valid,
  output logic [7:0]                      key_data,
  output logic                            key_ext,
  output logic                            key_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  output logic                            frame_err
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_PREFIX_DECODE_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data.
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          filt_clk_d;
  logic          fe, d_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      filt_clk_d <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1      <= {ps2_data, ps2_clk};
      sync2      <= sync1;
      filt_clk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign fe    = filt_clk_d & ~filt[0];
  assign d_bit = filt[1];

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout, frame_good, err_det;
  logic          byte_evt;
  logic [7:0]    byte_val;

  // Timeout fires one cycle early so the registered error lands TIMEOUT_CYC cycles after the last edge.
  assign timeout    = (state != ST_IDLE) && !fe && (tcnt == TW'(TIMEOUT_CYC - 2));
  assign frame_good = (^shift_reg ^ par_bit) & d_bit;
  assign err_det    = timeout
                    || (fe && state == ST_IDLE && d_bit)
                    || (fe && state == ST_STOP && !frame_good);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      par_bit   <= 1'b0;
      tcnt      <= '0;
      byte_evt  <= 1'b0;
      byte_val  <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_det;
      byte_evt  <= fe && (state == ST_STOP) && frame_good;
      byte_val  <= shift_reg;
      if (state == ST_IDLE || fe) tcnt <= '0;
      else                        tcnt <= tcnt + TW'(1);
      if (timeout) begin
        state <= ST_IDLE;
      end else if (fe) begin
        case (state)
          ST_IDLE: begin
            if (!d_bit) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_reg <= {d_bit, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= d_bit;
            state   <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  logic          push_req;
  logic [EW-1:0] push_entry;

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_pend, brk_pend;

  always_comb begin
    push_req   = byte_evt && (byte_val != 8'hE0) && (byte_val != 8'hF0);
    push_entry = {ext_pend, brk_pend, byte_val};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (err_det) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_evt) begin
      if (byte_val == 8'hE0) begin
        ext_pend <= 1'b1;
      end else if (byte_val == 8'hF0) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end
`else
  always_comb begin
    push_req   = byte_evt;
    push_entry = byte_val;
  end
`endif

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok;
  logic [EW-1:0] head;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd_en && key_valid;
  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign key_valid  = (count != '0);
  assign fifo_count = count;
  assign key_data   = key_valid ? head[7:0] : 8'h00;
`ifdef PS2_PREFIX_DECODE_EN
  assign key_break  = key_valid & head[8];
  assign key_ext    = key_valid & head[9];
`else
  assign key_break  = 1'b0;
  assign key_ext    = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are bit-banged onto the pins, expected
// entries are queued as frames are sent and compared as the FIFO is drained.
module tb_ps2_rx_fifo;

  localparam int FILTER_LEN  = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 10;
  localparam int GAP         = 20;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_data, rd_en;
  logic       key_valid, key_ext, key_break, overflow, frame_err;
  logic [7:0] key_data;
  logic [3:0] fifo_count;

  ps2_rx_fifo #(
    .FILTER_LEN (FILTER_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ext   (key_ext),
    .key_break (key_break),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int err_pulses = 0;
  int err_cycle = 0;
  int ovf_pulses = 0;
  int exp_err = 0;
  int exp_ovf = 0;
  int last_fall = 0;
  logic [9:0] sb [$];
  logic model_ext = 1'b0;
  logic model_brk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) begin
        err_pulses = err_pulses + 1;
        err_cycle  = cyc;
      end
      if (overflow) ovf_pulses = ovf_pulses + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [9:0] e);
    if (sb.size() < FIFO_DEPTH) sb.push_back(e);
    else exp_ovf++;
  endtask

  // Reference prefix folding for a good byte.
  task automatic model_byte(input logic [7:0] b);
`ifdef PS2_PREFIX_DECODE_EN
    if (b == 8'hE0) model_ext = 1'b1;
    else if (b == 8'hF0) model_brk = 1'b1;
    else begin
      push_exp({model_ext, model_brk, b});
      model_ext = 1'b0;
      model_brk = 1'b0;
    end
`else
    push_exp({2'b00, b});
`endif
  endtask

  task automatic model_error();
    exp_err++;
    model_ext = 1'b0;
    model_brk = 1'b0;
  endtask

  // Sends the first nbits of a frame (start, 8 data LSB first, odd parity, stop).
  task automatic applyStimulus(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      ps2_data = fr[k];
      repeat (HALF) @(negedge clk);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    applyStimulus(b, 1'b0, 11);
    model_byte(b);
  endtask

  task automatic drain_check(input string tag);
    while (sb.size() > 0) begin
      logic [9:0] e;
      e = sb.pop_front();
      checkOutput({tag, ".valid"}, key_valid, 1);
      checkOutput({tag, ".data"},  key_data,  e[7:0]);
      checkOutput({tag, ".break"}, key_break, e[8]);
      checkOutput({tag, ".ext"},   key_ext,   e[9]);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    checkOutput({tag, ".empty"}, key_valid, 0);
    checkOutput({tag, ".errs"},  err_pulses, exp_err);
    checkOutput({tag, ".ovfs"},  ovf_pulses, exp_ovf);
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_en    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst.valid", key_valid, 0);
    checkOutput("rst.count", fifo_count, 0);
    checkOutput("rst.data",  key_data, 0);
    checkOutput("rst.flags", {key_ext, key_break, overflow, frame_err}, 0);

    send_good(8'h1C);
    checkOutput("single.count", fifo_count, 1);
    drain_check("single");

    send_good(8'hF0);
    send_good(8'h1C);
    checkOutput("brk.count", fifo_count, sb.size());
    drain_check("brk");

    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    send_good(8'h75);
    checkOutput("extbrk.count", fifo_count, sb.size());
    drain_check("extbrk");

    applyStimulus(8'h1C, 1'b1, 11);
    model_error();
    checkOutput("par.count", fifo_count, 0);
    checkOutput("par.err", err_pulses, exp_err);
    send_good(8'h29);
    drain_check("par");

    // Start plus four data bits, then silence until the timeout aborts the frame.
    begin
      int base, waited;
      base   = err_pulses;
      waited = 0;
      applyStimulus(8'h29, 1'b0, 5);
      while (err_pulses == base && waited < TIMEOUT_CYC + 100) begin
        @(negedge clk);
        waited++;
      end
      model_error();
      checkOutput("tmo.err", err_pulses, exp_err);
      checkOutput("tmo.latency", err_cycle - last_fall, TIMEOUT_CYC + FILTER_LEN + 2);
      repeat (5) @(negedge clk);
      checkOutput("tmo.single", err_pulses, exp_err);
    end
    send_good(8'h29);
    drain_check("tmo");

    for (int i = 1; i <= 9; i++) send_good(8'(i));
    checkOutput("ovf.count", fifo_count, FIFO_DEPTH);
    checkOutput("ovf.pulses", ovf_pulses, 1);
    drain_check("ovf");

    // A two-cycle low blip on the clock must not start a frame.
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
    send_good(8'h1C);
    drain_check("glitch");

    applyStimulus(8'h55, 1'b0, 4);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst.count", fifo_count, 0);
    send_good(8'h29);
    drain_check("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver with input synchronisation, glitch filtering, odd-parity and stop-bit checking, a frame timeout, and a first-word-fall-through scan-code FIFO. It sits between the board PS/2 pins and the game-control logic, such as paddle control. Consumers pop one decoded scan code per `rd_en`. Optional prefix decoding folds the `E0` (extended) and `F0` (break) prefixes into flags on each entry.

## Interface
- `FILTER_LEN`, default 4: consecutive equal samples needed before a filtered line changes; range ≥2.
- `FIFO_DEPTH`, default 8: number of FIFO entries; must be a power of 2, ≥2.
- `TIMEOUT_CYC`, default 200000: `clk` cycles without a filtered falling edge before a frame in progress is aborted.
- `clk` input 1: system clock; all logic runs on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock pin (asynchronous, idle high).
- `ps2_data` input 1: raw PS/2 data pin (asynchronous, idle high).
- `rd_en` input 1: pops the FIFO head; ignored when `key_valid`=0.
- `key_valid` output 1: FIFO not empty.
- `key_data` output 8: scan code at the FIFO head.
- `key_ext` output 1: head entry was preceded by `E0`.
- `key_break` output 1: head entry was preceded by `F0`.
- `fifo_count` output $clog2(FIFO_DEPTH+1): current number of entries.
- `overflow` output 1: one-cycle pulse when a code is dropped because the FIFO is full.
- `frame_err` output 1: one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- **Synchronisers:** each pin passes through 2 flops, then a saturating filter. The filtered line takes the new level after `FILTER_LEN` consecutive equal samples.
- **Edge detect:** a falling edge of the filtered clock is a one-cycle strobe `fe`. Data is sampled from filtered `ps2_data` in the `fe` cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fe` with data=0, go to DATA with the bit count at 0. On `fe` with data=1, stay in IDLE and pulse `frame_err`.
  - DATA: shift bits in LSB first. After the 8th `fe`, go to PARITY.
  - PARITY: on `fe`, latch the parity bit and go to STOP.
  - STOP: on `fe`, the frame is good if XOR(8 data bits, parity)=1 and data=1. A good frame produces a byte event. Either way, return to IDLE. A bad frame pulses `frame_err` and produces no byte.
- **Timeout:** the counter clears on every `fe` and whenever the FSM is in IDLE. If it reaches `TIMEOUT_CYC` while not in IDLE, the FSM goes to IDLE, `frame_err` pulses and the partial byte is discarded.
- **Byte event:** a byte event becomes a FIFO push (raw, or via prefix decode; see Configuration).
- **FIFO behaviour:**
  - Push when full: the entry is dropped and `overflow` pulses; the contents are unchanged.
  - Push and pop in the same cycle while full: both take effect; the count stays at `FIFO_DEPTH` and there is no overflow.
  - Push and pop in the same cycle while empty: not possible, because a pop needs `key_valid`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset values:**
  - FSM in IDLE; FIFO empty; prefix flags clear.
  - Filtered lines and synchroniser flops at 1.
  - All outputs 0.
- **Reset mid-frame:** the partial frame is discarded. After release, the receiver resynchronises on the next start bit.

## Timing
- Pin falling edge to `fe`: 2 + `FILTER_LEN` cycles (±1 cycle of sampling uncertainty).
- Stop-bit `fe` in cycle N: the FIFO write happens at the end of cycle N+1. `key_valid`, `key_data`, `key_ext`, `key_break` and `fifo_count` update from cycle N+2.
- `overflow` and `frame_err` are registered and high for exactly one cycle: N+2 for overflow, and the cycle after detection for `frame_err`.
- Pop: with `rd_en`=1 and `key_valid`=1 in cycle M, the next head (or `key_valid`=0) appears in cycle M+1.
- FWFT: the head is valid combinationally from the RAM/register read whenever `key_valid`=1. No read latency.

## Configuration
- Macro: `PS2_PREFIX_DECODE_EN`.
- **Defined:**
  - Byte `E0` sets `ext_pend`; byte `F0` sets `brk_pend`. Neither is pushed.
  - Any other byte pushes {`ext_pend`, `brk_pend`, byte} and clears both flags.
  - `frame_err` clears both flags.
- **Undefined:** every good byte is pushed raw, `key_ext` and `key_break` are constant 0, and no prefix registers exist.

## Test plan
- **Single frame:** frame with data 0x1C, parity 0, stop 1 -> one entry: `key_data`=0x1C, `key_ext`=0, `key_break`=0, `fifo_count`=1, no `frame_err`. After `rd_en`, `key_valid`=0.
- **Break prefix:**
  - With the macro: frames F0, 1C -> exactly one entry, 0x1C with `key_break`=1.
  - Without the macro: two entries, 0xF0 then 0x1C.
- **Extended break:** with the macro, frames E0, F0, 75 -> one entry: 0x75, `key_ext`=1, `key_break`=1. A following plain 0x75 -> 0x75 with both flags 0.
- **Parity error:** 0x1C sent with parity 1 -> one `frame_err` pulse, `fifo_count` stays 0. The next good 0x29 frame is received correctly.
- **Truncated frame:** start bit plus 4 data bits, then the lines go idle -> `frame_err` exactly `TIMEOUT_CYC` cycles after the last `fe`. A following good 0x29 frame is received.
- **Overflow and glitch:**
  - 9 frames 0x01..0x09 with no reads (`FIFO_DEPTH`=8) -> `fifo_count`=8 and `overflow` pulses once. Pops return 0x01..0x08 in order.
  - A 2-cycle low glitch on `ps2_clk` (`FILTER_LEN`=4) produces no `fe`, and the frame state is unchanged.
